// File: rtl/disp_hex_demux_amisha.sv
// Recovers four hex digits and decimal points from a multiplexed, active-low 7-segment drive.
// Each digit must hold steady for STABLE_CYC samples before it is accepted into the frame.
module disp_hex_demux_amisha #(
    parameter int unsigned STABLE_CYC = 2
) (
    input  logic       clk_amisha,
    input  logic       reset_amisha,
    input  logic [3:0] an_amisha,
    input  logic [7:0] sseg_amisha,
    output logic [3:0] hex3_amisha,
    output logic [3:0] hex2_amisha,
    output logic [3:0] hex1_amisha,
    output logic [3:0] hex0_amisha,
    output logic [3:0] dp_out_amisha,
    output logic       frame_valid_amisha,
    output logic       seg_err_amisha
);

    localparam logic [3:0] CntMax   = 4'(STABLE_CYC - 1);
    localparam logic [3:0] CntMaxM1 = 4'(STABLE_CYC - 2);

    // Returns {ok, value}; ok=0 for any pattern outside the hex glyph set.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] res;
        unique case (seg)
            7'b0000001: res = 5'h10;
            7'b1001111: res = 5'h11;
            7'b0010010: res = 5'h12;
            7'b0000110: res = 5'h13;
            7'b1001100: res = 5'h14;
            7'b0100100: res = 5'h15;
            7'b0100000: res = 5'h16;
            7'b0001111: res = 5'h17;
            7'b0000000: res = 5'h18;
            7'b0000100: res = 5'h19;
            7'b0001000: res = 5'h1A;
            7'b1100000: res = 5'h1B;
            7'b0110001: res = 5'h1C;
            7'b1000010: res = 5'h1D;
            7'b0110000: res = 5'h1E;
            7'b0111000: res = 5'h1F;
            default:    res = 5'h00;
        endcase
        return res;
    endfunction

    logic [3:0] r_an_prev;
    logic [7:0] r_sseg_prev;
    logic [3:0] r_cnt;
    logic [3:0] r_stage [4];
    logic [3:0] r_stage_dp;
    logic [3:0] r_seen;
    logic [3:0] r_hex [4];
    logic [3:0] r_dp_out;
    logic       r_frame_valid;
    logic       r_seg_err;

    logic       w_an_valid;
    logic [1:0] w_idx;
    logic       w_match;
    logic [3:0] w_cnt_d;
    logic       w_stable_hit;
    logic [4:0] w_dec;
    logic       w_commit;
    logic       w_bad;
    logic [3:0] w_sel;
    logic [3:0] w_seen_nxt;
    logic       w_frame_done;
    logic [3:0] w_stage_nxt [4];
    logic [3:0] w_stage_dp_nxt;

    always_comb begin
        w_an_valid = 1'b1;
        w_idx      = 2'd0;
        unique case (an_amisha)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_an_valid = 1'b0;
        endcase
    end

    assign w_match = w_an_valid && (an_amisha == r_an_prev) && (sseg_amisha == r_sseg_prev);

    always_comb begin
        w_cnt_d = 4'd0;
        if (w_match) begin
            w_cnt_d = (r_cnt == CntMax) ? CntMax : r_cnt + 4'd1;
        end
    end

    // With a single-sample window every valid sample is a fresh acceptance.
    assign w_stable_hit = (STABLE_CYC == 1) ? w_an_valid : (w_match && (r_cnt == CntMaxM1));

    assign w_dec        = seg_decode(sseg_amisha[6:0]);
    assign w_commit     = w_stable_hit && w_dec[4];
    assign w_bad        = w_stable_hit && !w_dec[4];
    assign w_sel        = 4'b0001 << w_idx;
    assign w_seen_nxt   = w_commit ? (r_seen | w_sel) : r_seen;
    assign w_frame_done = w_commit && (w_seen_nxt == 4'b1111);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_stage_nxt[i] = r_stage[i];
        end
        w_stage_dp_nxt = r_stage_dp;
        if (w_commit) begin
            w_stage_nxt[w_idx]    = w_dec[3:0];
            w_stage_dp_nxt[w_idx] = ~sseg_amisha[7];
        end
    end

    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            r_an_prev     <= 4'b1111;
            r_sseg_prev   <= 8'hFF;
            r_cnt         <= 4'd0;
            r_stage_dp    <= 4'd0;
            r_seen        <= 4'd0;
            r_dp_out      <= 4'd0;
            r_frame_valid <= 1'b0;
            r_seg_err     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_stage[i] <= 4'd0;
                r_hex[i]   <= 4'd0;
            end
        end else begin
            r_an_prev     <= an_amisha;
            r_sseg_prev   <= sseg_amisha;
            r_cnt         <= w_cnt_d;
            r_stage_dp    <= w_stage_dp_nxt;
            r_frame_valid <= w_frame_done;
            if (w_bad) begin
                r_seg_err <= 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                r_stage[i] <= w_stage_nxt[i];
            end
            if (w_frame_done) begin
                r_seen   <= 4'd0;
                r_dp_out <= w_stage_dp_nxt;
                for (int i = 0; i < 4; i++) begin
                    r_hex[i] <= w_stage_nxt[i];
                end
            end else begin
                r_seen <= w_seen_nxt;
            end
        end
    end

    assign hex0_amisha        = r_hex[0];
    assign hex1_amisha        = r_hex[1];
    assign hex2_amisha        = r_hex[2];
    assign hex3_amisha        = r_hex[3];
    assign dp_out_amisha      = r_dp_out;
    assign frame_valid_amisha = r_frame_valid;
    assign seg_err_amisha     = r_seg_err;

endmodule
